// File: rtl/wb_hram_arbiter.sv
// Round-robin Wishbone N:1 arbiter in front of the HyperRAM data port; grants last a whole cyc tenure.
// Optional hung-slave timeout (and timeout_o port) is enabled by defining WB_HRAM_ARB_TIMEOUT_EN.
module wb_hram_arbiter #(
  parameter int NM = 3,
  parameter int AW = 32,
  parameter int DW = 32
`ifdef WB_HRAM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM*AW-1:0]       m_adr_i,
  input  logic [NM*DW-1:0]       m_dat_i,
  input  logic [NM*(DW/8)-1:0]   m_sel_i,
  input  logic [NM*3-1:0]        m_cti_i,
  input  logic [NM*2-1:0]        m_bte_i,
  output logic [DW-1:0]          m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW-1:0]          s_dat_o,
  output logic [DW/8-1:0]        s_sel_o,
  output logic [2:0]             s_cti_o,
  output logic [1:0]             s_bte_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [NM-1:0]          grant_o,
  output logic                   busy_o
`ifdef WB_HRAM_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  localparam int SW = DW / 8;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_r;
  logic [NM-1:0]   grant_r;
  logic [PW-1:0]   gidx_r;
  logic [PW-1:0]   ptr_r;
  logic            busy_r;
  logic [PW-1:0]   next_idx_s;
  logic [PW-1:0]   wrap_idx_s;
  logic            found_s;
  logic            live_s;
  logic            pass_s;
  logic            blk_s;
  logic            hit_s;

  logic [AW-1:0]   adr_a [NM];
  logic [DW-1:0]   dat_a [NM];
  logic [SW-1:0]   sel_a [NM];
  logic [2:0]      cti_a [NM];
  logic [1:0]      bte_a [NM];
  logic [PW-1:0]   cand_s [NM];

  function automatic logic [NM-1:0] onehot(input logic [PW-1:0] idx);
    logic [NM-1:0] v;
    v      = {NM{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign adr_a[i]  = m_adr_i[i*AW +: AW];
    assign dat_a[i]  = m_dat_i[i*DW +: DW];
    assign sel_a[i]  = m_sel_i[i*SW +: SW];
    assign cti_a[i]  = m_cti_i[i*3 +: 3];
    assign bte_a[i]  = m_bte_i[i*2 +: 2];
    assign cand_s[i] = PW'((int'(ptr_r) + i) % NM);
  end

  assign found_s    = |m_cyc_i;
  assign wrap_idx_s = (gidx_r == PW'(NM - 1)) ? {PW{1'b0}} : gidx_r + PW'(1);
  assign live_s     = (state_r == GRANT) && !wb_rst_i;
  assign pass_s     = live_s && m_cyc_i[gidx_r] && !blk_s;
  assign m_dat_o    = s_dat_i;
  assign grant_o    = grant_r;
  assign busy_o     = busy_r;

  // Round-robin pick: scanning backwards leaves the first requester at or after ptr.
  always_comb begin
    next_idx_s = ptr_r;
    for (int k = NM - 1; k >= 0; k--) begin
      next_idx_s = m_cyc_i[cand_s[k]] ? cand_s[k] : next_idx_s;
    end
  end

  // Tenure FSM: grant on any request, release when the granted master drops cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      grant_r <= {NM{1'b0}};
      gidx_r  <= {PW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r <= GRANT;
            gidx_r  <= next_idx_s;
            grant_r <= onehot(next_idx_s);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (!m_cyc_i[gidx_r]) begin
            state_r <= IDLE;
            grant_r <= {NM{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= wrap_idx_s;
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {NM{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Slave-side mux of the granted master, forced idle when not passing through.
  always_comb begin
    if (pass_s) begin
      s_cyc_o = 1'b1;
      s_stb_o = m_stb_i[gidx_r];
      s_we_o  = m_we_i[gidx_r];
      s_adr_o = adr_a[gidx_r];
      s_dat_o = dat_a[gidx_r];
      s_sel_o = sel_a[gidx_r];
      s_cti_o = cti_a[gidx_r];
      s_bte_o = bte_a[gidx_r];
    end else begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = {AW{1'b0}};
      s_dat_o = {DW{1'b0}};
      s_sel_o = {SW{1'b0}};
      s_cti_o = 3'b000;
      s_bte_o = 2'b00;
    end
  end

  // Route ack/err back to the granted master only.
  always_comb begin
    m_ack_o = {NM{1'b0}};
    m_err_o = {NM{1'b0}};
    if (live_s) begin
      m_ack_o[gidx_r] = s_ack_i && !blk_s;
      m_err_o[gidx_r] = (s_err_i && !blk_s) || hit_s;
    end else begin
      m_ack_o = {NM{1'b0}};
      m_err_o = {NM{1'b0}};
    end
  end

`ifdef WB_HRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;
  logic          abort_r;
  logic          timeout_r;

  // Hit is computed from the master's raw request so it cannot loop through s_cyc_o.
  assign hit_s     = live_s && m_cyc_i[gidx_r] && m_stb_i[gidx_r] && !abort_r &&
                     !s_ack_i && !s_err_i && (cnt_r == CW'(TIMEOUT - 1));
  assign blk_s     = abort_r || hit_s;
  assign timeout_o = timeout_r;

  // Stall counter and abort latch; abort holds until the tenure ends.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_r     <= {CW{1'b0}};
      abort_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r != GRANT) begin
        cnt_r   <= {CW{1'b0}};
        abort_r <= 1'b0;
      end else if (hit_s) begin
        cnt_r   <= {CW{1'b0}};
        abort_r <= 1'b1;
      end else if (s_ack_i || s_err_i) begin
        cnt_r   <= {CW{1'b0}};
      end else if (pass_s && m_stb_i[gidx_r]) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= cnt_r;
      end
      timeout_r <= timeout_r || hit_s;
    end
  end
`else
  assign hit_s = 1'b0;
  assign blk_s = 1'b0;
`endif

endmodule

// File: tb/tb_wb_hram_arbiter.sv
// Self-checking bench for wb_hram_arbiter: per-cycle vector table through a scoreboard queue,
// followed by a hand-written latency sequence.
module tb_wb_hram_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [3:0]        s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack, s_err;
  logic [NM-1:0]     grant;
  logic              busy;
`ifdef WB_HRAM_ARB_TIMEOUT_EN
  logic              timeout;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_hram_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_cti_i  (m_cti),
    .m_bte_i  (m_bte),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel),
    .s_cti_o  (s_cti),
    .s_bte_o  (s_bte),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .grant_o  (grant),
`ifdef WB_HRAM_ARB_TIMEOUT_EN
    .busy_o   (busy),
    .timeout_o(timeout)
`else
    .busy_o   (busy)
`endif
  );

  // One cycle of stimulus plus the state it should observe; src=3 means slave side idle.
  typedef struct {
    logic       rst;
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack;
    logic       err;
    logic [2:0] cti;
    logic [2:0] eg;
    logic       eb;
    logic [1:0] src;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input logic r, input logic [2:0] c, input logic [2:0] s, input logic a,
                     input logic e, input logic [2:0] t, input logic [2:0] g, input logic b,
                     input logic [1:0] src);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.cti = t;
    v.eg = g; v.eb = b; v.src = src;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int k);
    rst     = v.rst;
    m_cyc   = v.cyc;
    m_stb   = v.stb;
    s_ack   = v.ack;
    s_err   = v.err;
    s_dat_i = 32'h5A5A_0000 + k;
    for (int i = 0; i < NM; i++) m_cti[i*3 +: 3] = v.cti;
  endtask

  task automatic check_vec(input vec_t v, input int k);
    logic [2:0] ea, ee;
    int s;
    ea = (v.eb && !v.rst) ? (v.eg & {3{v.ack}}) : 3'b000;
    ee = (v.eb && !v.rst) ? (v.eg & {3{v.err}}) : 3'b000;
    check($sformatf("v%0d grant", k), 32'(grant), 32'(v.eg));
    check($sformatf("v%0d busy", k), 32'(busy), 32'(v.eb));
    check($sformatf("v%0d s_cyc", k), 32'(s_cyc), 32'(v.src != 2'd3));
    check($sformatf("v%0d m_ack", k), 32'(m_ack_o), 32'(ea));
    check($sformatf("v%0d m_err", k), 32'(m_err_o), 32'(ee));
    check($sformatf("v%0d m_dat", k), m_dat_o, 32'h5A5A_0000 + k);
    if (v.src != 2'd3) begin
      s = int'(v.src);
      check($sformatf("v%0d s_stb", k), 32'(s_stb), 32'(v.stb[s]));
      check($sformatf("v%0d s_adr", k), s_adr, 32'h4000_0000 + 32'h100 * s);
      check($sformatf("v%0d s_dat", k), s_dat_o, 32'hA5A5_0000 + s);
      check($sformatf("v%0d s_we", k), 32'(s_we), 32'(s == 0));
      check($sformatf("v%0d s_sel", k), 32'(s_sel), 32'(4'hF >> s));
      check($sformatf("v%0d s_cti", k), 32'(s_cti), 32'(v.cti));
      check($sformatf("v%0d s_bte", k), 32'(s_bte), 32'(s));
    end else begin
      check($sformatf("v%0d s_stb idle", k), 32'(s_stb), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; m_cyc = 3'b000; m_stb = 3'b000; m_we = 3'b001;
    s_ack = 1'b0; s_err = 1'b0; s_dat_i = 32'h0; m_cti = '0;
    for (int i = 0; i < NM; i++) begin
      m_adr[i*AW +: AW] = 32'h4000_0000 + 32'h100 * i;
      m_dat[i*DW +: DW] = 32'hA5A5_0000 + i;
      m_sel[i*4 +: 4]   = 4'hF >> i;
      m_bte[i*2 +: 2]   = 2'(i);
    end

    // reset, then all three request: grants 0,1,2,0 with one idle cycle between tenures
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 2'd0);
    add(1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2);
    add(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'd0);
    add(1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'd3);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    // master 2 alone, three tenures; afterwards 0 and 1 together must pick 0 (ptr=0)
    for (int t = 0; t < 3; t++) begin
      add(1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
      add(1'b0, 3'b100, 3'b100, 1'(t != 2), 1'b0, 3'b000, 3'b100, 1'b1, 2'd2);
      add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd3);
    end
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'd0);
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'd3);
    // slave err on master 1 read
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b1, 3'b000, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 2'd3);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    // master 1 8-beat burst with an stb gap; master 0 requests mid-burst
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b011, 3'b001, 1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    for (int b = 0; b < 4; b++)
      add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 2'd3);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    // master 0 write burst, reset during beat 3; then 1 and 2 request: ptr=0 picks 1
    add(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b010, 3'b001, 1'b1, 2'd0);
    add(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b010, 3'b001, 1'b1, 2'd0);
    add(1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 3'b010, 3'b001, 1'b1, 2'd3);
    add(1'b0, 3'b110, 3'b110, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 2'd1);
    add(1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 2'd3);
    add(1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);
    add(1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd3);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd3);

    repeat (2) @(posedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      apply(tbl[k], k);
      exp_q.push_back(tbl[k]);
      #4;
      check_vec(exp_q.pop_front(), k);
    end

    // all three request from ptr=0: granted one edge later, master 0 first
    m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b0; s_err = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 8);
    check("hs grant latency", 32'(n), 32'd1);
    check("hs grant first", 32'(grant), 32'(3'b001));
    // master 0 leaves: busy falls one edge later, master 1 granted after one idle cycle
    m_cyc = 3'b110; m_stb = 3'b110;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 8);
    check("hs release latency", 32'(n), 32'd1);
    check("hs idle s_cyc", 32'(s_cyc), 32'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 8);
    check("hs regrant latency", 32'(n), 32'd1);
    check("hs grant second", 32'(grant), 32'(3'b010));
    check("hs s_adr second", s_adr, 32'h4000_0100);
    m_cyc = 3'b000; m_stb = 3'b000;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
